// File: rtl/prng_lfsr80_rnd_if.sv
// Handshake bundle between the randomness source and its seeding/consuming logic.
// RND must match the security_order-derived width of the attached prng_lfsr80_rnd.
interface prng_lfsr80_rnd_if #(
    parameter int RND = 1
) ();
    logic           reseed;
    logic [15:0]    seed_in;
    logic           seed_valid;
    logic           seed_ready;
    logic [RND-1:0] r;
    logic           rnd_valid;
    logic           rnd_ready;

    modport master (
        output reseed,
        output seed_in,
        output seed_valid,
        output rnd_ready,
        input  seed_ready,
        input  r,
        input  rnd_valid
    );

    modport slave (
        input  reseed,
        input  seed_in,
        input  seed_valid,
        input  rnd_ready,
        output seed_ready,
        output r,
        output rnd_valid
    );
endinterface

// File: rtl/prng_lfsr80_rnd.sv
// Seeded 80-bit Fibonacci LFSR delivering RND fresh bits per consumer handshake
// for the r input of an HPC2 masked AND gadget.
module prng_lfsr80_rnd #(
    parameter int security_order = 1,
    parameter int WARMUP         = 160
) (
    input  logic              clk,
    input  logic              rst_n,
    prng_lfsr80_rnd_if.slave  bus
);
    localparam int RND = security_order * (security_order + 1) / 2;
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [79:0]    s_q, s_d;
    logic [2:0]     word_q, word_d;
    logic [WCW-1:0] warm_q, warm_d;

    // chain[i] is the state after i single steps; chain[RND] is one full advance.
    logic [79:0] chain [RND+1];
    logic [79:0] seed_shift;
    logic [79:0] seed_load;

    assign chain[0] = s_q;

    generate
        for (genvar gi = 0; gi < RND; gi++) begin : g_step
            assign chain[gi+1] = {chain[gi][78:0],
                                  chain[gi][79] ^ chain[gi][78] ^ chain[gi][42] ^ chain[gi][41]};
        end
        for (genvar gi = 0; gi < RND; gi++) begin : g_out
            assign bus.r[gi] = s_q[79-gi];
        end
    endgenerate

    assign seed_shift = {s_q[63:0], bus.seed_in};

    always_comb begin
        seed_load = seed_shift;
        // An all-zero state would lock the LFSR forever.
        if (word_q == 3'd4 && seed_shift == 80'd0) begin
            seed_load = 80'd1;
        end
    end

    assign bus.seed_ready = (state_q == LOAD);
    assign bus.rnd_valid  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        word_d  = word_q;
        warm_d  = warm_q;
        if (bus.reseed) begin
            state_d = LOAD;
            word_d  = 3'd0;
            warm_d  = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.seed_valid) begin
                        s_d = seed_load;
                        if (word_q == 3'd4) begin
                            word_d = 3'd0;
                            if (WARMUP > 0) begin
                                state_d = WARM;
                                warm_d  = WCW'(WARMUP);
                            end else begin
                                state_d = RUN;
                            end
                        end else begin
                            word_d = word_q + 3'd1;
                        end
                    end
                end
                WARM: begin
                    s_d    = chain[RND];
                    warm_d = warm_q - WCW'(1);
                    if (warm_q <= WCW'(1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.rnd_ready) begin
                        s_d = chain[RND];
                    end
                end
                default: begin
                    state_d = LOAD;
                    word_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            s_q     <= '0;
            word_q  <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            word_q  <= word_d;
            warm_q  <= warm_d;
        end
    end
endmodule

// File: tb/tb_prng_lfsr80_rnd.sv
// Scoreboard bench: three instances (order 1 / order 3 without warmup, order 1 with
// WARMUP=160); expected r words are queued at stimulus time and popped per handshake.
module tb_prng_lfsr80_rnd;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prng_lfsr80_rnd_if #(.RND(1)) if0 ();
    prng_lfsr80_rnd_if #(.RND(6)) if1 ();
    prng_lfsr80_rnd_if #(.RND(1)) if2 ();

    prng_lfsr80_rnd #(.security_order(1), .WARMUP(0))   u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    prng_lfsr80_rnd #(.security_order(3), .WARMUP(0))   u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    prng_lfsr80_rnd #(.security_order(1), .WARMUP(160)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    int n_vec  = 0;
    int n_miss = 0;
    logic [79:0] exp_q0[$];
    logic [79:0] exp_q1[$];
    logic [79:0] exp_q2[$];
    logic [79:0] m_st [3];
    int          rndw [3] = '{1, 6, 1};

    localparam logic [79:0] SEED_A = {16'h8000, 64'h0};
    localparam logic [79:0] SEED_B = 80'h1234_5678_9abc_def0_0f1e;

    function automatic logic [79:0] step1(input logic [79:0] s);
        return {s[78:0], s[79] ^ s[78] ^ s[42] ^ s[41]};
    endfunction

    function automatic logic [79:0] stepn(input logic [79:0] s, input int n);
        logic [79:0] v = s;
        for (int i = 0; i < n; i++) v = step1(v);
        return v;
    endfunction

    function automatic logic [79:0] rbits(input logic [79:0] s, input int n);
        logic [79:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = s[79-k];
        return v;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [79:0] get_r(input int d);
        case (d)
            0: return 80'(if0.r);
            1: return 80'(if1.r);
            default: return 80'(if2.r);
        endcase
    endfunction

    function automatic logic get_valid(input int d);
        case (d)
            0: return if0.rnd_valid;
            1: return if1.rnd_valid;
            default: return if2.rnd_valid;
        endcase
    endfunction

    function automatic logic get_sready(input int d);
        case (d)
            0: return if0.seed_ready;
            1: return if1.seed_ready;
            default: return if2.seed_ready;
        endcase
    endfunction

    task automatic set_seed(input int d, input logic sv, input logic [15:0] w);
        case (d)
            0: begin if0.seed_valid = sv; if0.seed_in = w; end
            1: begin if1.seed_valid = sv; if1.seed_in = w; end
            default: begin if2.seed_valid = sv; if2.seed_in = w; end
        endcase
    endtask

    task automatic set_rr(input int d, input logic rr);
        case (d)
            0: if0.rnd_ready = rr;
            1: if1.rnd_ready = rr;
            default: if2.rnd_ready = rr;
        endcase
    endtask

    task automatic set_rs(input int d, input logic rs);
        case (d)
            0: if0.reseed = rs;
            1: if1.reseed = rs;
            default: if2.reseed = rs;
        endcase
    endtask

    task automatic push_exp(input int d, input logic [79:0] v);
        case (d)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Five seed words, first word first, with one idle gap after the second word.
    task automatic load5(input int d, input logic [79:0] sd);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                set_seed(d, 1'b0, 16'h0);
                tick();
            end
            check($sformatf("seed_ready_w%0d_u%0d", i, d), 80'(get_sready(d)), 80'h1);
            set_seed(d, 1'b1, sd[79-16*i -: 16]);
            tick();
        end
        set_seed(d, 1'b0, 16'h0);
        m_st[d] = (sd == 80'd0) ? 80'd1 : sd;
    endtask

    // Consume n words with rnd_ready held high; expectations come from the model.
    task automatic run_n(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(d, rbits(m_st[d], rndw[d]));
            m_st[d] = stepn(m_st[d], rndw[d]);
            set_rr(d, 1'b1);
            tick();
        end
        set_rr(d, 1'b0);
    endtask

    task automatic mon_pop(input string name, input logic [79:0] act, inout logic [79:0] q[$]);
        if (q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: extra output %h, expected none", name, act);
        end else begin
            check(name, act, q.pop_front());
        end
    endtask

    always @(negedge clk)
        if (rst_n && if0.rnd_valid && if0.rnd_ready && !if0.reseed) mon_pop("r_u0", 80'(if0.r), exp_q0);
    always @(negedge clk)
        if (rst_n && if1.rnd_valid && if1.rnd_ready && !if1.reseed) mon_pop("r_u1", 80'(if1.r), exp_q1);
    always @(negedge clk)
        if (rst_n && if2.rnd_valid && if2.rnd_ready && !if2.reseed) mon_pop("r_u2", 80'(if2.r), exp_q2);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            set_seed(d, 1'b0, 16'h0);
            set_rr(d, 1'b0);
            set_rs(d, 1'b0);
            m_st[d] = '0;
        end
        #3;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_seed_ready_u%0d", d), 80'(get_sready(d)), 80'h1);
            check($sformatf("rst_rnd_valid_u%0d", d), 80'(get_valid(d)), 80'h0);
            check($sformatf("rst_r_u%0d", d), get_r(d), 80'h0);
        end
        #4 rst_n = 1'b1;
        tick();

        // Known sequence, order 1, no warmup: hand values 1, 0 then the model.
        load5(0, SEED_A);
        check("valid_after_5th_u0", 80'(get_valid(0)), 80'h1);
        push_exp(0, 80'h1);
        push_exp(0, 80'h0);
        set_rr(0, 1'b1);
        tick();
        tick();
        m_st[0] = stepn(SEED_A, 2);
        run_n(0, 20);

        // seed_valid in RUN is ignored and r holds without rnd_ready.
        set_seed(0, 1'b1, 16'hffff);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("run_seed_ready_u0", 80'(get_sready(0)), 80'h0);
            check("run_hold_r_u0", get_r(0), rbits(m_st[0], 1));
        end
        set_seed(0, 1'b0, 16'h0);

        // Reseed racing a consumer handshake: no advance, back to LOAD.
        set_rs(0, 1'b1);
        set_rr(0, 1'b1);
        tick();
        set_rs(0, 1'b0);
        set_rr(0, 1'b0);
        check("reseed_valid_u0", 80'(get_valid(0)), 80'h0);
        check("reseed_ready_u0", 80'(get_sready(0)), 80'h1);
        check("reseed_r_u0", get_r(0), rbits(m_st[0], 1));
        load5(0, SEED_A);
        push_exp(0, 80'h1);
        push_exp(0, 80'h0);
        set_rr(0, 1'b1);
        tick();
        tick();
        set_rr(0, 1'b0);
        m_st[0] = stepn(SEED_A, 2);

        // Zero seed: state forced to 80'h1; the lone 1 reaches s[79] after 79 steps.
        set_rs(0, 1'b1);
        tick();
        set_rs(0, 1'b0);
        load5(0, 80'd0);
        check("zero_seed_first_r", get_r(0), 80'h0);
        run_n(0, 79);
        check("zero_seed_nonconst", get_r(0), 80'h1);
        run_n(0, 11);

        // Wide unroll, order 3: first r hand-computed as 6'b000001.
        load5(1, SEED_A);
        check("valid_after_5th_u1", 80'(get_valid(1)), 80'h1);
        push_exp(1, 80'h01);
        set_rr(1, 1'b1);
        tick();
        m_st[1] = stepn(SEED_A, 6);
        run_n(1, 4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stall_r_u1_c%0d", i), get_r(1), rbits(m_st[1], 6));
        end
        run_n(1, 6);

        // Warmup latency, then reset in mid-WARM.
        load5(2, SEED_B);
        check("warm_valid_u2", 80'(get_valid(2)), 80'h0);
        check("warm_ready_u2", 80'(get_sready(2)), 80'h0);
        repeat (50) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready_u2", 80'(get_sready(2)), 80'h1);
        check("async_rst_valid_u2", 80'(get_valid(2)), 80'h0);
        check("async_rst_r_u2", get_r(2), 80'h0);
        #2 rst_n = 1'b1;
        tick();
        load5(2, SEED_B);
        cnt = 0;
        while (!get_valid(2) && cnt < 400) begin
            tick();
            cnt++;
        end
        check("warm_latency_u2", 80'(cnt + 1), 80'd161);
        m_st[2] = stepn(SEED_B, 160);
        run_n(2, 5);

        tick();
        check("q0_drained", 80'(exp_q0.size()), 80'h0);
        check("q1_drained", 80'(exp_q1.size()), 80'h0);
        check("q2_drained", 80'(exp_q2.size()), 80'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/prng_lfsr80_rnd.md
# prng_lfsr80_rnd

Seeded fresh-randomness source for HPC2 masked AND gadgets: it produces the `rnd = security_order*(security_order+1)/2` random bits a gadget consumes on its `r` input each cycle. It is built on an 80-bit Fibonacci LFSR that is loaded by a 16-bit seed handshake and optionally warmed up before use. The state advances only on a consumer handshake, so no random bit is ever delivered twice. It sits directly upstream of the gadget `r` port.

## Interface
- `security_order`, default 1: masking order. Output width is `RND = security_order*(security_order+1)/2`. Legal range is 1..12, so that `RND` ≤ 80.
- `WARMUP`, default 160: number of discard cycles after seeding. 0 is legal.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `reseed` input, 1 bit: single-cycle request to restart seeding.
- `seed_in` input, 16 bits: seed word.
- `seed_valid` input, 1 bit: `seed_in` is valid.
- `seed_ready` output, 1 bit: the block accepts a seed word.
- `r` output, `RND` bits: random bits for the gadget `r` port.
- `rnd_valid` output, 1 bit: `r` is fresh and unused.
- `rnd_ready` input, 1 bit: the consumer takes `r` this cycle.

## Operation
- State: `s[79:0]`, FSM {LOAD, WARM, RUN}, word counter (0..4), warmup counter (0..WARMUP).
- Single LFSR step:
  - feedback `f = s[79]^s[78]^s[42]^s[41]`
  - output bit = `s[79]`
  - next state `s = {s[78:0], f}`
- Advance: `RND` consecutive single steps, unrolled combinationally within one cycle.
- Output mapping: `r[k] = s[79-k]` for k = 0..RND-1. This is pure wiring from the register, so `r` is glitch-free and `r[0]` is the first bit out.
- LOAD:
  - `seed_ready = 1`.
  - Each handshake (`seed_valid & seed_ready`) shifts `s <= {s[63:0], seed_in}` and increments the word counter.
  - On the 5th word, the first word lands in `s[79:64]`. If the assembled 80 bits are all zero, bit 0 is forced to 1 (prevents LFSR lock-up).
  - Next state after the 5th word: WARM if `WARMUP > 0`, else RUN.
- WARM:
  - Each cycle performs one advance and decrements the counter.
  - After `WARMUP` advances, move to RUN.
  - `seed_ready = 0`, `rnd_valid = 0`.
- RUN:
  - `rnd_valid = 1`.
  - When `rnd_valid & rnd_ready`, perform one advance; the new `r` is visible the next cycle.
  - With `rnd_ready = 0`, `s` and `r` hold.
  - `seed_ready = 0`; `seed_valid` is ignored.
- `reseed = 1`, any state:
  - Next cycle FSM = LOAD and word counter = 0.
  - `rnd_valid` and any WARM progress are dropped.
  - `s` is not cleared.
  - `reseed` has priority over a simultaneous seed or rnd handshake in that cycle: the handshake is not performed and `s` is unchanged.
- `seed_valid` held while `seed_ready = 0`: no effect; the word is not consumed.

## Timing
- Reset values:
  - `s = 0`, FSM = LOAD, counters = 0.
  - `seed_ready = 1`, `rnd_valid = 0`, `r = 0`.
- Reset asserted mid-operation: immediate return to the reset values, regardless of clock.
- `rnd_valid` first rises `1 + WARMUP` cycles after the 5th-word handshake edge. With `WARMUP = 0`, it is high in the cycle right after that edge.
- Throughput: one fresh `RND`-bit word per cycle while `rnd_ready` is held high. No bubbles.
- All outputs come directly from registers or from FSM decode. No combinational path from `rnd_ready` or `seed_valid` to any output.
- Seed words may arrive with gaps; the counter holds across idle cycles.

## Test plan
- Known sequence: `WARMUP = 0`, `security_order = 1`, seed words 16'h8000, then four × 16'h0000, `rnd_ready = 1`. Required `r` sequence is 1, 0, then the reference-model LFSR sequence. `rnd_valid` is high the cycle after the 5th word.
- Wide unroll: `security_order = 3` (`RND = 6`), same seed, `WARMUP = 0`. First `r = 6'b000001` (`r[0] = 1`). Second `r` must equal the model's single-step bits 6..11.
- Stall: in RUN, drop `rnd_ready` for 10 cycles. `r` is stable for all 10 cycles, and the next value after release matches the model with no skipped or repeated bits.
- Zero seed: five words of 16'h0000, `WARMUP = 0`. The state becomes 80'h1 and the first `r[0] = 0`. The sequence is non-constant afterwards.
- Reseed race: assert `reseed` in RUN in the same cycle as `rnd_ready = 1`. Next cycle `rnd_valid = 0` and `seed_ready = 1`, and `s` is unchanged. Reseeding with the first test's seed reproduces 1, 0, ….
- Reset and warmup: pull `rst_n` low in mid-WARM (`WARMUP = 160`). All outputs are at reset values asynchronously. After re-seeding, `rnd_valid` rises exactly 161 cycles after the 5th-word edge.
